// File: rtl/shift_add_mul8_if.sv
// Operand/result bundle for the 8x8 shift-add multiplier.
// The operand source drives start/a/b; the multiplier drives the rest.
interface shift_add_mul8_if #(
  parameter int WIDTH = 8
);
  logic                     start;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic [2*WIDTH-1:0]       product;
  logic                     done;
  logic                     busy;
  logic                     valid;
  logic [$clog2(WIDTH)-1:0] step;

  modport master (
    output start, a, b,
    input  product, done, busy, valid, step
  );

  modport slave (
    input  start, a, b,
    output product, done, busy, valid, step
  );
endinterface

// File: rtl/shift_add_mul8.sv
// Sequential unsigned shift-add multiplier: WIDTH accumulate cycles
// plus one settle cycle, driving a downstream capture register.
module shift_add_mul8 #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  shift_add_mul8_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   product_q, product_d;
  logic [SW-1:0]   step_q, step_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      step_q    <= '0;
      done_q    <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      step_q    <= step_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    step_d    = step_q;
    done_d    = done_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d   = {{WIDTH{1'b0}}, bus.a};
          mplier_d  = bus.b;
          product_d = '0;
          step_d    = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          product_d = product_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + SW'(1);
        // Fixed iteration count: no early exit on a zero multiplier.
        if (step_q == SW'(WIDTH - 1)) begin
          step_d  = '0;
          state_d = LAST;
        end
      end
      LAST: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.step    = step_q;
endmodule

// File: tb/tb_shift_add_mul8.sv
// Bench for shift_add_mul8: per-cycle reference model plus
// directed literal checks and randomized start traffic.
module tb_shift_add_mul8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  shift_add_mul8_if #(.WIDTH(8)) bus ();

  shift_add_mul8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] cap = '0;
  always @(posedge clk) begin
    if (!bus.done) cap <= bus.product;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = cycles since acceptance (0..9), -1 when idle.
  int          k = -1;
  int unsigned ma = 0;
  int unsigned mb = 0;
  int unsigned hold = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = -1;
      hold = 0;
    end else if (k == -1 || k == 9) begin
      if (bus.start) begin
        ma = bus.a;
        mb = bus.b;
        k = 0;
      end else begin
        k = -1;
      end
    end else begin
      k++;
      if (k == 9) hold = ma * mb;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int unsigned ep;
      int          es;
      bit          ed, eb, ev;
      if (k < 0) begin
        ep = hold; ed = 1; eb = 0; ev = 0; es = 0;
      end else if (k <= 8) begin
        ep = ma * (mb & ((1 << k) - 1));
        ed = 0; eb = 1; ev = 0;
        es = (k < 8) ? k : 0;
      end else begin
        ep = ma * mb; ed = 1; eb = 0; ev = 1; es = 0;
      end
      check("product", 32'(bus.product), ep);
      check("done", 32'(bus.done), 32'(ed));
      check("busy", 32'(bus.busy), 32'(eb));
      check("valid", 32'(bus.valid), 32'(ev));
      check("step", 32'(bus.step), es);
    end
  end

  task automatic issue(logic [7:0] x, logic [7:0] y);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end while (!bus.valid && cyc < 20);
    if (!bus.valid) check("valid_timeout", 0, 1);
  endtask

  task automatic do_op(logic [7:0] x, logic [7:0] y, logic [15:0] exp);
    int lat;
    @(negedge clk);
    issue(x, y);
    wait_valid(lat);
    check("latency", lat, 9);
    check("result", 32'(bus.product), 32'(exp));
    @(negedge clk);
    check("valid_once", 32'(bus.valid), 0);
  endtask

  initial begin
    logic [15:0] seq [8];
    int lat;
    seq = '{16'd13, 16'd39, 16'd39, 16'd143, 16'd143,
            16'd143, 16'd143, 16'd143};
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_product", 32'(bus.product), 0);
    check("rst_done", 32'(bus.done), 1);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_done", 32'(bus.done), 1);

    // 13 x 11 with per-edge partial products
    issue(8'd13, 8'd11);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("partial", 32'(bus.product), 32'(seq[i]));
    end
    @(posedge clk);
    @(negedge clk);
    check("mul13x11_valid", 32'(bus.valid), 1);
    check("mul13x11", 32'(bus.product), 32'h008F);
    @(negedge clk);
    check("capture", 32'(cap), 32'h008F);

    do_op(8'hFF, 8'hFF, 16'hFE01);
    do_op(8'h00, 8'hAB, 16'h0000);
    do_op(8'h80, 8'h02, 16'h0100);

    // Start while busy is ignored
    @(negedge clk);
    issue(8'd3, 8'd5);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 8'd7;
    bus.b = 8'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_valid(lat);
    check("busy_start_lat", lat, 5);
    check("busy_start_res", 32'(bus.product), 32'h000F);
    repeat (12) @(negedge clk);
    check("no_second_op", 32'(bus.busy), 0);

    // Back-to-back issue in the valid cycle
    @(negedge clk);
    issue(8'd3, 8'd5);
    wait_valid(lat);
    check("b2b_first", 32'(bus.product), 32'h000F);
    issue(8'd7, 8'd9);
    wait_valid(lat);
    check("b2b_interval", lat + 1, 10);
    check("b2b_second", 32'(bus.product), 32'h003F);

    // Reset mid-operation
    @(negedge clk);
    issue(8'hFF, 8'hFF);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_product", 32'(bus.product), 0);
    check("midrst_done", 32'(bus.done), 1);
    check("midrst_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_op(8'd2, 8'd3, 16'h0006);

    // Random traffic, including start noise while busy
    repeat (400) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
    end
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_add_mul8.md
Name: shift_add_mul8

Overview:
Sequential unsigned 8x8 shift-add multiplier. It is the producing side of the result-capture register in the 8x8mul datapath. It drives the 16-bit running product and a done flag: the capture register loads the product while done=0 and holds it once done=1. One multiplication takes a fixed 8 accumulate cycles plus one settle cycle, with a start/busy handshake toward the operand source.

Parameters:
WIDTH, 8, operand width in bits. Product width is 2*WIDTH. The step counter is clog2(WIDTH) bits. All values below assume WIDTH=8.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request to begin a multiplication; sampled only in IDLE.
a  input  8  multiplicand, latched on start acceptance.
b  input  8  multiplier, latched on start acceptance.
product  output  16  running/final product (registered); feeds the capture register "in".
done  output  1  0 while computing (capture register loads), 1 otherwise (capture register holds).
busy  output  1  1 from start acceptance until return to IDLE.
valid  output  1  one-cycle pulse: the capture register now holds the final product.
step  output  3  index of the multiplier bit processed in the current RUN cycle; 0 outside RUN.

Behaviour:
- Reset: rst low → state IDLE, product=0, done=1, busy=0, valid=0, step=0, internal mcand/mplier=0. Takes effect immediately, including mid-operation; the partial result is discarded. An edge with rst low never accepts start.
- States: IDLE, RUN, LAST. All outputs are registered; none is combinational from inputs.
- IDLE: done=1, busy=0. On an edge with start=1:
  - latch mcand={8'b0,a}, mplier=b;
  - clear product to 0, set step=0;
  - done←0, busy←1, go to RUN.
  - With start=0, all registers hold.
- RUN, at each edge:
  - if mplier[0]=1: product←product+mcand (16-bit add; cannot overflow since the max is 0xFE01);
  - mcand←mcand<<1, mplier←mplier>>1, step←step+1.
  - At the edge where step=7, go to LAST; step←0.
  - Exactly 8 RUN cycles occur regardless of operand values (no early exit).
- LAST: product holds its final value, done stays 0 for this one cycle so the capture register samples the final product. At the next edge: done←1, busy←0, valid←1, go to IDLE.
- valid is high for exactly the first IDLE cycle after LAST, then returns to 0.
- Latency: start sampled at edge 0 → product final after edge 8 → done=1/valid=1 after edge 9.
- done=0 spans exactly 9 consecutive cycles per operation.
- start asserted in RUN or LAST is ignored, not queued. Changes to a or b after acceptance have no effect.
- Back-to-back: start high in the cycle where valid=1 is accepted at the next edge (state is IDLE). Minimum issue interval is 10 cycles.
- product holds its last final value through IDLE until the next acceptance clears it to 0.

Test Plan:
- Reset: hold rst=0 → product=0x0000, done=1, busy=0, valid=0, step=0. Release rst with start=0 → all outputs unchanged for 5 cycles.
- a=13, b=11: product after RUN edges 1..8 = 13, 39, 39, 143, 143, 143, 143, 143; final 0x008F. done=0 for 9 cycles; valid pulses once at cycle 10; a capture register downstream reads 0x008F.
- Extremes: 0xFF×0xFF → 0xFE01; 0x00×0xAB → 0x0000; 0x80×0x02 → 0x0100. Each has latency 9 and a single valid pulse.
- Start while busy: a=3, b=5, then at RUN step 3 pulse start with a=7, b=9 → result 0x000F. No second operation follows; busy falls once.
- Back-to-back: 3×5 then start asserted in the valid cycle with 7×9 → 0x000F, one IDLE cycle, then 0x003F. Two valid pulses 10 cycles apart.
- Reset mid-op: a=0xFF, b=0xFF, drop rst at RUN step 4 → immediately product=0, done=1, busy=0. After release, 2×3 → 0x0006 with normal latency.
